// File: rtl/spart_io_arbiter_pkg.sv
// rtl/spart_io_arbiter_pkg.sv - shared types and constants for the SPART I/O arbiter
package spart_io_pkg;

   // Top-level sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_e;

   // SPART memory-mapped register addresses
   localparam logic [27:0] SPART_DATA_ADDR   = 28'h800_0000;
   localparam logic [27:0] SPART_STATUS_ADDR = 28'h800_0001;

   // Default bus widths
   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/spart_io_arbiter_if.sv
// rtl/spart_io_arbiter_if.sv - requester and downstream SPART bus bundle
interface spart_io_arbiter_if #(
   parameter int ADDR_W = spart_io_pkg::DEF_ADDR_W,
   parameter int DATA_W = spart_io_pkg::DEF_DATA_W
);
   // Requester side (bit/slice 0 = CPU, 1 = NPU)
   logic [1:0]          req_valid;
   logic [1:0]          req_rw;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          req_ready;
   logic                req_err;
   logic [DATA_W-1:0]   req_rdata;

   // Downstream SPART cache-side port
   logic                io_valid_data;
   logic                io_rw_data;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   io_wr_data;
   logic                io_ready_data;
   logic [DATA_W-1:0]   io_rd_data;

   // Arbiter view
   modport master (
      input  req_valid, req_rw, req_addr, req_wdata,
      output req_ready, req_err, req_rdata,
      output io_valid_data, io_rw_data, mem_addr, io_wr_data,
      input  io_ready_data, io_rd_data
   );

   // Environment view (requesters plus SPART)
   modport slave (
      output req_valid, req_rw, req_addr, req_wdata,
      input  req_ready, req_err, req_rdata,
      input  io_valid_data, io_rw_data, mem_addr, io_wr_data,
      output io_ready_data, io_rd_data
   );

endinterface

// File: rtl/spart_io_arbiter_rr_arb2.sv
// rtl/spart_io_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_id,
   output logic       gnt_any
);

   // Sole requester wins; on contention the one not granted last time wins
   always_comb begin
      gnt_any = |req;
      if (req == 2'b11) begin
         gnt_id = ~last;
      end else begin
         gnt_id = req[1];
      end
   end

endmodule

// File: rtl/spart_io_arbiter.sv
// rtl/spart_io_arbiter.sv - CPU/NPU arbiter and sequencer for the SPART I/O port
module spart_io_arbiter
   import spart_io_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W
) (
   input  logic clk,
   input  logic rst,
   output logic busy,
   spart_io_arbiter_if.master bus
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              io_valid_q, io_valid_d;
   logic              io_rw_q, io_rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        ready_q, ready_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              busy_q, busy_d;

   logic              arb_id;
   logic              arb_any;
   logic              timed_out;
   logic              sel_rw;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req     (bus.req_valid),
      .last    (last_q),
      .gnt_id  (arb_id),
      .gnt_any (arb_any)
   );

   // Command of the current arbitration winner and the timeout condition
   always_comb begin
      sel_rw    = arb_id ? bus.req_rw[1] : bus.req_rw[0];
      sel_addr  = arb_id ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
      sel_wdata = arb_id ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      timed_out = (cnt_q == CNT_LAST);
   end

   // State register; reset drops any in-flight downstream request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: grant from IDLE, finish REQ on ready or timeout, single GAP cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_any) state_d = REQ;
         REQ:     if (bus.io_ready_data || timed_out) state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-values; ready wins over a coincident timeout
   always_comb begin
      last_d     = last_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      io_valid_d = io_valid_q;
      io_rw_d    = io_rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      ready_d    = 2'b00;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               last_d     = arb_id;
               gnt_d      = arb_id;
               cnt_d      = '0;
               io_valid_d = 1'b1;
               io_rw_d    = sel_rw;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
            end
         end
         REQ: begin
            if (bus.io_ready_data) begin
               io_valid_d = 1'b0;
               rdata_d    = io_rw_q ? '0 : bus.io_rd_data;
               ready_d    = gnt_q ? 2'b10 : 2'b01;
            end else if (timed_out) begin
               io_valid_d = 1'b0;
               rdata_d    = '0;
               err_d      = 1'b1;
               ready_d    = gnt_q ? 2'b10 : 2'b01;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         cnt_q      <= '0;
         io_valid_q <= 1'b0;
         io_rw_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ready_q    <= 2'b00;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         cnt_q      <= cnt_d;
         io_valid_q <= io_valid_d;
         io_rw_q    <= io_rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.io_valid_data = io_valid_q;
   assign bus.io_rw_data    = io_rw_q;
   assign bus.mem_addr      = addr_q;
   assign bus.io_wr_data    = wdata_q;
   assign bus.req_ready     = ready_q;
   assign bus.req_err       = err_q;
   assign bus.req_rdata     = rdata_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_spart_io_arbiter.sv
// tb/tb_spart_io_arbiter.sv - scoreboard bench for spart_io_arbiter
module tb_spart_io_arbiter;
   import spart_io_pkg::*;

   localparam int AW = 28;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;

   spart_io_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   spart_io_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk  (clk),
      .rst  (rst),
      .busy (busy),
      .bus  (bus)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic          id;
      logic          err;
      logic [DW-1:0] rdata;
   } cpl_t;

   cmd_t cmd_q[$];
   cpl_t cpl_q[$];

   int checks = 0;
   int failures = 0;

   int            resp_delay = 0;
   bit            echo = 1'b0;
   logic [DW-1:0] resp_data = '0;
   bit            in_req = 1'b0;
   int            req_cycles = 0;
   int            low_cnt = 0;
   bit            gap_chk = 1'b0;
   bit            seen_rise = 1'b0;
   cmd_t          cur;
   int            last_len = 0;
   int            rem [2];
   int            next_k [2];
   int            done_cnt = 0;

   function automatic logic [DW-1:0] echo_data(input logic [AW-1:0] a);
      return {4'hA, a} ^ 32'h0005_A5A5;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int id, input logic rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input logic exp_err);
      cmd_t c;
      cpl_t e;
      bus.req_rw[id]               = rw;
      bus.req_addr[id*AW +: AW]    = addr;
      bus.req_wdata[id*DW +: DW]   = wdata;
      bus.req_valid[id]            = 1'b1;
      c.rw = rw; c.addr = addr; c.wdata = wdata;
      e.id = id[0]; e.err = exp_err; e.rdata = exp_rdata;
      cmd_q.push_back(c);
      cpl_q.push_back(e);
   endtask

   task automatic pair_issue(input int id);
      logic [AW-1:0] a;
      a = SPART_DATA_ADDR + AW'(id * 16 + next_k[id]);
      next_k[id]++;
      issue(id, 1'b0, a, '0, echo_data(a), 1'b0);
   endtask

   // One clock: SPART responder model, downstream command checks, completion scoreboard
   task automatic cycle();
      cpl_t e;
      int   id;
      @(negedge clk);
      if (bus.io_valid_data) begin
         if (!in_req) begin
            in_req = 1'b1;
            req_cycles = 0;
            if (gap_chk && seen_rise) check("gap_len", 64'(low_cnt), 64'd2);
            seen_rise = 1'b1;
            low_cnt = 0;
            if (cmd_q.size() == 0) begin
               check("cmd_unexpected", 64'd1, 64'd0);
               cur = '0;
            end else begin
               cur = cmd_q.pop_front();
            end
            check("cmd_rw", 64'(bus.io_rw_data), 64'(cur.rw));
            check("cmd_addr", 64'(bus.mem_addr), 64'(cur.addr));
            check("cmd_wdata", 64'(bus.io_wr_data), 64'(cur.wdata));
         end else if ({bus.io_rw_data, bus.mem_addr, bus.io_wr_data} !== cur) begin
            check("cmd_stable", 64'({bus.io_rw_data, bus.mem_addr, bus.io_wr_data}), 64'(cur));
         end
         bus.io_ready_data = (resp_delay >= 0) && (req_cycles == resp_delay);
         bus.io_rd_data    = echo ? echo_data(bus.mem_addr) : resp_data;
         req_cycles++;
      end else begin
         if (in_req) last_len = req_cycles;
         in_req = 1'b0;
         bus.io_ready_data = 1'b0;
         low_cnt++;
      end
      if (bus.req_ready !== 2'b00) begin
         done_cnt++;
         check("gap_valid_low", 64'(bus.io_valid_data), 64'd0);
         if (cpl_q.size() == 0) begin
            check("cpl_unexpected", 64'(bus.req_ready), 64'd0);
         end else begin
            e = cpl_q.pop_front();
            check("ready_id", 64'(bus.req_ready), e.id ? 64'd2 : 64'd1);
            check("ready_err", 64'(bus.req_err), 64'(e.err));
            check("ready_rdata", 64'(bus.req_rdata), 64'(e.rdata));
         end
         id = bus.req_ready[1] ? 1 : 0;
         if (rem[id] > 0) begin
            rem[id]--;
            pair_issue(id);
         end else begin
            bus.req_valid[id] = 1'b0;
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         cycle();
         n++;
      end while ((cpl_q.size() != 0 || busy) && n < budget);
      check("wait_budget", 64'(n >= budget), 64'd0);
   endtask

   initial begin
      rem[0] = 0; rem[1] = 0;
      next_k[0] = 0; next_k[1] = 0;
      bus.req_valid     = '0;
      bus.req_rw        = '0;
      bus.req_addr      = '0;
      bus.req_wdata     = '0;
      bus.io_ready_data = 1'b0;
      bus.io_rd_data    = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_io_valid", 64'(bus.io_valid_data), 64'd0);
      check("rst_io_rw", 64'(bus.io_rw_data), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_io_wr", 64'(bus.io_wr_data), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_err", 64'(bus.req_err), 64'd0);
      check("rst_rdata", 64'(bus.req_rdata), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b1;
      cycle();

      // Contended from reset: CPU first, then strict alternation over 8 pairs
      gap_chk = 1'b1; seen_rise = 1'b0; echo = 1'b1; resp_delay = 0; done_cnt = 0;
      pair_issue(0);
      pair_issue(1);
      rem[0] = 7; rem[1] = 7;
      wait_idle(400);
      check("pair_count", 64'(done_cnt), 64'd16);
      check("pair_valid_clear", 64'(bus.req_valid), 64'd0);
      gap_chk = 1'b0; echo = 1'b0;

      // CPU read, ready after 4 REQ cycles
      resp_delay = 3; resp_data = 32'h0000_0041;
      issue(0, 1'b0, SPART_DATA_ADDR, '0, 32'h41, 1'b0);
      cycle();
      check("grant_latency", 64'(bus.io_valid_data), 64'd1);
      wait_idle(50);
      check("read_len", 64'(last_len), 64'd4);

      // NPU write; read data bus carries junk that must not leak
      resp_delay = 2; resp_data = 32'h1234_5678;
      issue(1, 1'b1, SPART_DATA_ADDR, 32'hDEAD_BEEF, 32'h0, 1'b0);
      wait_idle(50);

      // Timeout, then a normal transaction
      resp_delay = -1; resp_data = 32'hFFFF_FFFF;
      issue(0, 1'b0, SPART_STATUS_ADDR, '0, 32'h0, 1'b1);
      wait_idle(50);
      check("timeout_len", 64'(last_len), 64'd8);
      resp_delay = 1; resp_data = 32'h0BAD_F00D;
      issue(1, 1'b0, SPART_STATUS_ADDR, '0, 32'h0BAD_F00D, 1'b0);
      wait_idle(50);

      // Ready on the exact timeout cycle wins
      resp_delay = 7; resp_data = 32'h5555_AAAA;
      issue(0, 1'b0, SPART_DATA_ADDR, '0, 32'h5555_AAAA, 1'b0);
      wait_idle(50);
      check("edge_len", 64'(last_len), 64'd8);

      // NPU request arriving mid-REQ is held off, not lost
      resp_delay = 3; resp_data = 32'h0000_00C3;
      issue(0, 1'b0, SPART_DATA_ADDR, '0, 32'hC3, 1'b0);
      cycle();
      cycle();
      issue(1, 1'b0, SPART_STATUS_ADDR, '0, 32'hC3, 1'b0);
      wait_idle(80);

      // Reset mid-REQ: async drop, no completion, CPU wins afterwards
      resp_delay = -1;
      issue(0, 1'b0, SPART_DATA_ADDR, '0, 32'h0, 1'b0);
      repeat (3) cycle();
      check("pre_rst_valid", 64'(bus.io_valid_data), 64'd1);
      #3 rst = 1'b0;
      #1;
      check("arst_valid", 64'(bus.io_valid_data), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_ready", 64'(bus.req_ready), 64'd0);
      cmd_q.delete();
      cpl_q.delete();
      in_req = 1'b0;
      bus.req_valid = '0;
      bus.io_ready_data = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_no_ready", 64'(bus.req_ready), 64'd0);
      end
      rst = 1'b1;
      echo = 1'b1; resp_delay = 0; next_k[0] = 8; next_k[1] = 8;
      pair_issue(0);
      pair_issue(1);
      wait_idle(80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spart_io_arbiter.md
# spart_io_arbiter

Two-requester arbiter and sequencer for the SPART memory-mapped I/O port. Sits between the CPU and NPU I/O interfaces and the single SPART cache-side port (io_valid_data / io_rw_data / io_ready_data). It grants one requester at a time with round-robin fairness and holds the downstream request until the SPART completes. It enforces the mandatory idle cycle between downstream transactions and aborts stalled transactions after a timeout.

## Interface
- TIMEOUT_CYCLES, 1024: downstream cycles allowed before abort. Legal range is 2 to 65535.
- ADDR_W, 28: I/O address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester valid. Bit 0 is the CPU, bit 1 is the NPU.
- req_rw  in  2  per-requester direction: 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-requester address. Requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-requester write data.
- req_ready  out  2  per-requester completion pulse.
- req_err  out  1  valid with req_ready. 1 = transaction aborted by timeout.
- req_rdata  out  DATA_W  read data, shared. Valid with req_ready.
- io_valid_data  out  1  downstream request valid.
- io_rw_data  out  1  downstream direction.
- mem_addr  out  ADDR_W  downstream address.
- io_wr_data  out  DATA_W  downstream write data.
- io_ready_data  in  1  downstream completion.
- io_rd_data  in  DATA_W  downstream read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - If any req_valid bit is set, grant the winner and latch its rw, addr and wdata into output registers.
  - Assert io_valid_data and go to REQ.
- Arbitration is round-robin on a 1-bit last-granted pointer `last`.
  - Only one requester valid: it wins.
  - Both valid: requester ~last wins.
  - `last` updates at grant.
- REQ:
  - io_valid_data stays high, and the latched command stays stable.
  - On io_ready_data = 1: capture io_rd_data into req_rdata (zero for writes), deassert io_valid_data, and go to GAP.
  - The timeout counter increments every REQ cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: deassert io_valid_data, set req_err, force req_rdata = 0, and go to GAP.
- GAP (exactly one cycle):
  - io_valid_data = 0. This cycle lets the downstream SPART handshake counter clear.
  - Pulse req_ready[grant] for this one cycle, with req_err.
  - Return to IDLE.
- The requester must hold valid and its command stable until its req_ready pulse.
  - A requester deasserting valid mid-transaction does not abort it. The transaction completes downstream and the ready pulse is still issued.
- io_ready_data is ignored in IDLE and GAP.
- Reset mid-operation: all state clears immediately. The downstream request is dropped without a completion pulse.

## Timing
- Reset values:
  - io_valid_data = 0, io_rw_data = 0, mem_addr = 0, io_wr_data = 0.
  - req_ready = 0, req_err = 0, req_rdata = 0.
  - busy = 0, `last` = 1, so the CPU wins the first contended grant.
  - Timeout counter = 0, state = IDLE.
- All outputs are registered.
- Grant latency: req_valid sampled high in IDLE at edge N gives io_valid_data high after edge N.
- Completion: io_ready_data high sampled at edge M gives req_ready high for cycle M+1 only. The earliest next grant is at edge M+2.
- Minimum transaction is 3 cycles: IDLE, REQ (1 cycle), GAP.
- Simultaneous events:
  - io_ready_data on the same edge the counter hits TIMEOUT_CYCLES-1: ready wins, req_err = 0.
  - A new req_valid arriving during REQ or GAP is held off until IDLE. It is never lost as long as the requester holds valid.
- The timeout counter is ceil(log2(TIMEOUT_CYCLES)) bits. It clears on entry to REQ and does not wrap.

## Structure
- A shared package spart_io_pkg holds:
  - the state typedef (IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2);
  - the SPART address constants (data 28'h800_0000, status 28'h800_0001);
  - the DATA_W and ADDR_W defaults.
- One sub-module: rr_arb2, a 2-way round-robin picker. Its inputs are req[1:0] and last; its outputs are gnt_id and gnt_any. It is purely combinational.
- The timeout counter and FSM stay in the top level.

## Test plan
- CPU read from 28'h800_0000, SPART ready after 4 cycles with io_rd_data = 32'h0000_0041 -> req_ready[0] pulses once with req_rdata = 32'h41 and req_err = 0. io_valid_data is low during GAP.
- Both requesters request in the same cycle from reset -> CPU is granted first, then NPU. Alternation continues over 8 back-to-back pairs, with exactly one GAP cycle between downstream requests.
- NPU write of 32'hDEAD_BEEF, CPU idle -> io_rw_data = 1 and io_wr_data = 32'hDEAD_BEEF, held stable until ready. req_ready[1] pulses with req_rdata = 0.
- TIMEOUT_CYCLES = 8 with io_ready_data never asserted -> io_valid_data drops after 8 REQ cycles. req_ready pulses with req_err = 1 and req_rdata = 0, and the next request proceeds normally.
- io_ready_data asserted on the exact timeout cycle -> req_err = 0 and read data is captured.
- rst asserted in the middle of REQ -> io_valid_data and busy go low asynchronously. No req_ready pulse is issued, and after release the CPU wins the first contended grant.
